rx_fc: RTL and testbench

- Receive-side flow-control credit manager, the counterpart of the transmit-side credit checker.
- Owns the credit limits this link partner advertises for the Posted (P), Non-Posted (NP) and Completion (CPL) classes.
- Produces InitFC/UpdateFC advertisements for the DLL on the HdrFC/DataFC/TypeFC bus, counts credits consumed by received TLPs, and flags receiver overflow.
- Sits between the DLL Rx path, the receive buffers and the DLLP generator.

---
 rtl/rx_fc_pkg.sv | 49 ++++
 rtl/rx_fc_credit_slot.sv | 52 +++++
 rtl/rx_fc.sv | 178 +++++++++++++++++
 tb/tb_rx_fc.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rx_fc_pkg.sv
// Shared types, state encodings, default credit limits and the PTLP-to-credit
// conversion used by both the receive and transmit flow-control logic.
package rx_fc_pkg;

    typedef enum logic [1:0] {
        FC_X   = 2'd0,
        FC_P   = 2'd1,
        FC_NP  = 2'd2,
        FC_CPL = 2'd3
    } FC_type_t;

    localparam logic [2:0] ST_INIT_P   = 3'd0;
    localparam logic [2:0] ST_INIT_NP  = 3'd1;
    localparam logic [2:0] ST_INIT_CPL = 3'd2;
    localparam logic [2:0] ST_IDLE     = 3'd3;
    localparam logic [2:0] ST_UPDATE   = 3'd4;

    localparam int P_HDR_INIT_DEF    = 30;
    localparam int P_DATA_INIT_DEF   = 1000;
    localparam int NP_HDR_INIT_DEF   = 15;
    localparam int NP_DATA_INIT_DEF  = 1000;
    localparam int CPL_HDR_INIT_DEF  = 30;
    localparam int CPL_DATA_INIT_DEF = 1000;

    // One data credit covers 4 DW, rounded up.
    function automatic logic [8:0] ptlp_to_credits(input logic [9:0] ptlp);
        logic [10:0] sum;
        sum = {1'b0, ptlp} + 11'd3;
        return sum[10:2];
    endfunction

    function automatic logic [2:0] type_onehot(input FC_type_t t);
        case (t)
            FC_P:    return 3'b001;
            FC_NP:   return 3'b010;
            FC_CPL:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic FC_type_t next_type(input FC_type_t t);
        case (t)
            FC_P:    return FC_NP;
            FC_NP:   return FC_CPL;
            default: return FC_P;
        endcase
    endfunction

endpackage

// File: rtl/rx_fc_credit_slot.sv
// Credit bookkeeping for one traffic class: advertised limit (CA), received
// count (CR) and the overflow check against the limit before any same-cycle release.
module rx_fc_credit_slot
    import rx_fc_pkg::*;
#(
    parameter int HW        = 12,
    parameter int DW        = 16,
    parameter int HDR_INIT  = 30,
    parameter int DATA_INIT = 1000
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          rx_en,
    input  logic [9:0]    rx_ptlp,
    input  logic          rel_en,
    input  logic [9:0]    rel_ptlp,
    output logic [HW-1:0] ca_hdr,
    output logic [DW-1:0] ca_data,
    output logic          overflow
);

    logic [HW-1:0] cr_hdr, new_cr_hdr, hdr_room;
    logic [DW-1:0] cr_data, new_cr_data, data_room;
    logic [DW-1:0] rx_cred, rel_cred;

    assign rx_cred     = DW'(ptlp_to_credits(rx_ptlp));
    assign rel_cred    = DW'(ptlp_to_credits(rel_ptlp));
    assign new_cr_hdr  = cr_hdr + HW'(1);
    assign new_cr_data = cr_data + rx_cred;
    assign hdr_room    = ca_hdr - new_cr_hdr;
    assign data_room   = ca_data - new_cr_data;
    assign overflow    = rx_en && (hdr_room[HW-1] || data_room[DW-1]);

    always_ff @(posedge clk) begin
        if (!arst) begin
            ca_hdr  <= HW'(HDR_INIT);
            ca_data <= DW'(DATA_INIT);
            cr_hdr  <= '0;
            cr_data <= '0;
        end else begin
            if (rel_en) begin
                ca_hdr  <= ca_hdr + HW'(1);
                ca_data <= ca_data + rel_cred;
            end
            if (rx_en && !overflow) begin
                cr_hdr  <= new_cr_hdr;
                cr_data <= new_cr_data;
            end
        end
    end

endmodule

// File: rtl/rx_fc.sv
// Receive-side flow-control credit manager: InitFC sequence, round-robin
// UpdateFC advertisements, periodic refresh and sticky receiver-overflow flag.
//
// state       | meaning
// ST_INIT_P   | advertising InitFC for Posted
// ST_INIT_NP  | advertising InitFC for Non-Posted
// ST_INIT_CPL | advertising InitFC for Completion
// ST_IDLE     | waiting for a pending class
// ST_UPDATE   | UpdateFC held until the DLL accepts it
module rx_fc
    import rx_fc_pkg::*;
#(
    parameter int FC_HDR_WIDTH  = 12,
    parameter int FC_DATA_WIDTH = 16,
    parameter int P_HDR_INIT    = P_HDR_INIT_DEF,
    parameter int P_DATA_INIT   = P_DATA_INIT_DEF,
    parameter int NP_HDR_INIT   = NP_HDR_INIT_DEF,
    parameter int NP_DATA_INIT  = NP_DATA_INIT_DEF,
    parameter int CPL_HDR_INIT  = CPL_HDR_INIT_DEF,
    parameter int CPL_DATA_INIT = CPL_DATA_INIT_DEF,
    parameter int UPDATE_PERIOD = 1024
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     rx_tlp_valid,
    input  FC_type_t                 rx_tlp_type,
    input  logic [9:0]               rx_tlp_ptlp,
    input  logic                     rel_valid,
    input  FC_type_t                 rel_type,
    input  logic [9:0]               rel_ptlp,
    output logic                     fc_valid,
    input  logic                     fc_ready,
    output FC_type_t                 TypeFC,
    output logic [FC_HDR_WIDTH-1:0]  HdrFC,
    output logic [FC_DATA_WIDTH-1:0] DataFC,
    output logic                     init_done,
    output logic                     rx_overflow_err,
    output FC_type_t                 overflow_type
);

    localparam int TW = $clog2(UPDATE_PERIOD);

    logic [2:0]               state;
    logic [2:0]               pending, pending_next, rel_vec, hs_clr;
    logic [TW-1:0]            timer;
    logic                     tick, upd_dirty;
    FC_type_t                 rr_ptr, pick, cand, load_type;
    logic [FC_HDR_WIDTH-1:0]  ca_hdr [3];
    logic [FC_DATA_WIDTH-1:0] ca_data [3];
    logic [FC_HDR_WIDTH-1:0]  load_hdr;
    logic [FC_DATA_WIDTH-1:0] load_data;
    logic [2:0]               ovf;

    for (genvar i = 0; i < 3; i++) begin : g_slot
        localparam logic [1:0] CLS = 2'(i + 1);
        rx_fc_credit_slot #(
            .HW       (FC_HDR_WIDTH),
            .DW       (FC_DATA_WIDTH),
            .HDR_INIT ((i == 0) ? P_HDR_INIT  : (i == 1) ? NP_HDR_INIT  : CPL_HDR_INIT),
            .DATA_INIT((i == 0) ? P_DATA_INIT : (i == 1) ? NP_DATA_INIT : CPL_DATA_INIT)
        ) u_slot (
            .clk     (clk),
            .arst    (arst),
            .rx_en   (init_done && rx_tlp_valid && (rx_tlp_type == CLS)),
            .rx_ptlp (rx_tlp_ptlp),
            .rel_en  (rel_valid && (rel_type == CLS)),
            .rel_ptlp(rel_ptlp),
            .ca_hdr  (ca_hdr[i]),
            .ca_data (ca_data[i]),
            .overflow(ovf[i])
        );
    end

    always_comb begin
        pick = FC_X;
        cand = rr_ptr;
        for (int k = 0; k < 3; k++) begin
            cand = next_type(cand);
            if (pick == FC_X && |(type_onehot(cand) & pending))
                pick = cand;
        end
    end

    always_comb begin
        load_type = TypeFC;
        case (state)
            ST_INIT_P:   load_type = (fc_valid && fc_ready) ? FC_NP  : FC_P;
            ST_INIT_NP:  load_type = (fc_valid && fc_ready) ? FC_CPL : FC_NP;
            ST_INIT_CPL: load_type = FC_CPL;
            ST_IDLE:     load_type = pick;
            default:     load_type = TypeFC;
        endcase
        load_hdr  = '0;
        load_data = '0;
        case (load_type)
            FC_P:    begin load_hdr = ca_hdr[0]; load_data = ca_data[0]; end
            FC_NP:   begin load_hdr = ca_hdr[1]; load_data = ca_data[1]; end
            FC_CPL:  begin load_hdr = ca_hdr[2]; load_data = ca_data[2]; end
            default: begin load_hdr = '0;        load_data = '0;         end
        endcase
    end

    // A release that lands while an UpdateFC is held keeps its class pending.
    assign tick    = init_done && (timer == TW'(UPDATE_PERIOD - 1));
    assign rel_vec = (rel_valid && init_done) ? type_onehot(rel_type) : 3'b000;
    assign hs_clr  = (state == ST_UPDATE && fc_ready && !upd_dirty) ? type_onehot(TypeFC) : 3'b000;
    assign pending_next = (pending & ~hs_clr) | rel_vec | (tick ? 3'b111 : 3'b000);

    always_ff @(posedge clk) begin
        if (!arst) begin
            state           <= ST_INIT_P;
            pending         <= '0;
            timer           <= '0;
            rr_ptr          <= FC_CPL;
            upd_dirty       <= 1'b0;
            fc_valid        <= 1'b0;
            TypeFC          <= FC_X;
            HdrFC           <= '0;
            DataFC          <= '0;
            init_done       <= 1'b0;
            rx_overflow_err <= 1'b0;
            overflow_type   <= FC_X;
        end else begin
            pending <= pending_next;
            if (init_done)
                timer <= tick ? '0 : timer + TW'(1);
            if (|ovf && !rx_overflow_err) begin
                rx_overflow_err <= 1'b1;
                overflow_type   <= rx_tlp_type;
            end
            case (state)
                ST_INIT_P, ST_INIT_NP: begin
                    if (!fc_valid || fc_ready) begin
                        fc_valid <= 1'b1;
                        TypeFC   <= load_type;
                        HdrFC    <= load_hdr;
                        DataFC   <= load_data;
                        if (fc_valid)
                            state <= (state == ST_INIT_P) ? ST_INIT_NP : ST_INIT_CPL;
                    end
                end
                ST_INIT_CPL: begin
                    if (!fc_valid) begin
                        fc_valid <= 1'b1;
                        TypeFC   <= load_type;
                        HdrFC    <= load_hdr;
                        DataFC   <= load_data;
                    end else if (fc_ready) begin
                        fc_valid  <= 1'b0;
                        init_done <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (|pending) begin
                        fc_valid  <= 1'b1;
                        TypeFC    <= load_type;
                        HdrFC     <= load_hdr;
                        DataFC    <= load_data;
                        upd_dirty <= rel_valid && (rel_type == pick);
                        state     <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    if (fc_ready) begin
                        fc_valid <= 1'b0;
                        rr_ptr   <= TypeFC;
                        state    <= ST_IDLE;
                    end else if (rel_valid && (rel_type == TypeFC)) begin
                        upd_dirty <= 1'b1;
                    end
                end
                default: state <= ST_INIT_P;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_fc.sv
// Directed bench for rx_fc: InitFC, UpdateFC, overflow, back-pressure,
// periodic refresh (second instance with a short period) and mid-update reset.
module tb_rx_fc;
    import rx_fc_pkg::*;

    logic        clk;
    logic        arst, rx_tlp_valid, rel_valid, fc_ready;
    FC_type_t    rx_tlp_type, rel_type;
    logic [9:0]  rx_tlp_ptlp, rel_ptlp;
    logic        fc_valid, init_done, rx_overflow_err;
    FC_type_t    TypeFC, overflow_type;
    logic [11:0] HdrFC;
    logic [15:0] DataFC;

    logic        t_arst, t_rx_valid, t_rel_valid, t_fc_ready;
    FC_type_t    t_rx_type, t_rel_type;
    logic [9:0]  t_rx_ptlp, t_rel_ptlp;
    logic        t_fc_valid, t_init_done, t_ovf_err;
    FC_type_t    t_TypeFC, t_ovf_type;
    logic [11:0] t_HdrFC;
    logic [15:0] t_DataFC;

    int checks = 0;
    int errors = 0;

    rx_fc dut (
        .clk(clk), .arst(arst),
        .rx_tlp_valid(rx_tlp_valid), .rx_tlp_type(rx_tlp_type), .rx_tlp_ptlp(rx_tlp_ptlp),
        .rel_valid(rel_valid), .rel_type(rel_type), .rel_ptlp(rel_ptlp),
        .fc_valid(fc_valid), .fc_ready(fc_ready), .TypeFC(TypeFC), .HdrFC(HdrFC), .DataFC(DataFC),
        .init_done(init_done), .rx_overflow_err(rx_overflow_err), .overflow_type(overflow_type)
    );

    rx_fc #(.UPDATE_PERIOD(16)) dut_tmr (
        .clk(clk), .arst(t_arst),
        .rx_tlp_valid(t_rx_valid), .rx_tlp_type(t_rx_type), .rx_tlp_ptlp(t_rx_ptlp),
        .rel_valid(t_rel_valid), .rel_type(t_rel_type), .rel_ptlp(t_rel_ptlp),
        .fc_valid(t_fc_valid), .fc_ready(t_fc_ready), .TypeFC(t_TypeFC), .HdrFC(t_HdrFC), .DataFC(t_DataFC),
        .init_done(t_init_done), .rx_overflow_err(t_ovf_err), .overflow_type(t_ovf_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_adv(input string tag, input FC_type_t t, input int hdr, input int data);
        chk({tag, "_valid"}, fc_valid, 1);
        chk({tag, "_type"}, TypeFC, t);
        chk({tag, "_hdr"}, HdrFC, hdr);
        chk({tag, "_data"}, DataFC, data);
    endtask

    task automatic apply_reset();
        arst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_init();
        fc_ready = 1'b1;
        arst     = 1'b1;
        @(negedge clk); chk_adv("init_p", FC_P, 30, 1000);
        @(negedge clk); chk_adv("init_np", FC_NP, 15, 1000);
        @(negedge clk); chk_adv("init_cpl", FC_CPL, 30, 1000);
        @(negedge clk);
        chk("init_done", init_done, 1);
        chk("init_idle_valid", fc_valid, 0);
    endtask

    task automatic release_one(input FC_type_t t, input logic [9:0] p);
        rel_valid = 1'b1; rel_type = t; rel_ptlp = p;
        @(negedge clk);
        rel_valid = 1'b0;
    endtask

    task automatic receive_one(input FC_type_t t, input logic [9:0] p);
        rx_tlp_valid = 1'b1; rx_tlp_type = t; rx_tlp_ptlp = p;
        @(negedge clk);
        rx_tlp_valid = 1'b0;
    endtask

    initial begin
        FC_type_t exp_t;
        arst = 1'b0; fc_ready = 1'b1;
        rx_tlp_valid = 1'b0; rx_tlp_type = FC_X; rx_tlp_ptlp = '0;
        rel_valid = 1'b0; rel_type = FC_X; rel_ptlp = '0;
        t_arst = 1'b0; t_fc_ready = 1'b1;
        t_rx_valid = 1'b0; t_rx_type = FC_X; t_rx_ptlp = '0;
        t_rel_valid = 1'b0; t_rel_type = FC_X; t_rel_ptlp = '0;

        repeat (2) @(negedge clk);
        chk("rst_valid", fc_valid, 0);
        chk("rst_type", TypeFC, FC_X);
        chk("rst_hdr", HdrFC, 0);
        chk("rst_data", DataFC, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_ovf", rx_overflow_err, 0);
        chk("rst_ovf_type", overflow_type, FC_X);

        // P release of 10 DW: 31 headers, 1000 + ceil(10/4) = 1003 data
        do_init();
        release_one(FC_P, 10'd10);
        chk("upd_p_not_yet", fc_valid, 0);
        @(negedge clk); chk_adv("upd_p", FC_P, 31, 1003);
        @(negedge clk); chk("upd_p_done", fc_valid, 0);

        // 31st posted header overruns the 30 advertised
        apply_reset(); do_init();
        for (int i = 0; i < 31; i++) begin
            receive_one(FC_P, 10'd0);
            if (i == 29) chk("ovf_p_30_ok", rx_overflow_err, 0);
        end
        chk("ovf_p_err", rx_overflow_err, 1);
        chk("ovf_p_type", overflow_type, FC_P);
        for (int i = 0; i < 16; i++) receive_one(FC_NP, 10'd0);
        chk("ovf_np_err", rx_overflow_err, 1);
        chk("ovf_np_type_kept", overflow_type, FC_P);

        // Completion data overrun: 3 x 256 = 768 fits, 4th makes 1024 > 1000
        apply_reset(); do_init();
        for (int i = 0; i < 4; i++) begin
            receive_one(FC_CPL, 10'd1023);
            if (i == 2) chk("ovf_cpl_3_ok", rx_overflow_err, 0);
        end
        chk("ovf_cpl_err", rx_overflow_err, 1);
        chk("ovf_cpl_type", overflow_type, FC_CPL);

        // Back-pressured NP update with a second NP release while held
        apply_reset(); do_init();
        fc_ready = 1'b0;
        release_one(FC_NP, 10'd4);
        @(negedge clk); chk_adv("hold_np1", FC_NP, 16, 1001);
        release_one(FC_NP, 10'd4);
        chk_adv("hold_np1_held", FC_NP, 16, 1001);
        @(negedge clk); chk_adv("hold_np1_held2", FC_NP, 16, 1001);
        fc_ready = 1'b1;
        @(negedge clk); chk("hold_np_gap", fc_valid, 0);
        @(negedge clk); chk_adv("hold_np2", FC_NP, 17, 1002);
        @(negedge clk); chk("hold_np2_done", fc_valid, 0);

        // Reset in the middle of a held CPL update restarts InitFC from defaults
        apply_reset(); do_init();
        fc_ready = 1'b0;
        release_one(FC_CPL, 10'd8);
        @(negedge clk); chk_adv("mid_cpl", FC_CPL, 31, 1002);
        arst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", fc_valid, 0);
        chk("mid_rst_init_done", init_done, 0);
        @(negedge clk);
        do_init();

        // Periodic refresh with a 16-cycle period and no traffic
        t_arst = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            case (n)
                1, 21, 37: exp_t = FC_P;
                2, 23, 39: exp_t = FC_NP;
                3, 25:     exp_t = FC_CPL;
                default:   exp_t = FC_X;
            endcase
            chk($sformatf("tmr_valid_%0d", n), t_fc_valid, (exp_t != FC_X) ? 1 : 0);
            if (exp_t != FC_X) begin
                chk($sformatf("tmr_type_%0d", n), t_TypeFC, exp_t);
                chk($sformatf("tmr_hdr_%0d", n), t_HdrFC, (exp_t == FC_NP) ? 15 : 30);
                chk($sformatf("tmr_data_%0d", n), t_DataFC, 1000);
            end
            if (n == 4) chk("tmr_init_done", t_init_done, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
